mini_cpu_core: RTL and testbench

//  Parametrised successor of the mini-CPU control block. Decodes switch instructions on a
//  btn_enviar rising edge and sequences the register RAM (dual-read, one-write) and the external ALU.

---
 rtl/mini_cpu_pkg.sv | 29 ++
 rtl/mini_cpu_sweep.sv | 24 ++
 rtl/mini_cpu_core.sv | 163 ++++++++++++++++
 tb/tb_mini_cpu_core.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared constants for the mini-CPU control block: opcodes, ALU codes and FSM encoding.
package mini_cpu_pkg;

   localparam int unsigned OP_LOAD    = 0;
   localparam int unsigned OP_ADD     = 1;
   localparam int unsigned OP_ADDI    = 2;
   localparam int unsigned OP_SUB     = 3;
   localparam int unsigned OP_SUBI    = 4;
   localparam int unsigned OP_MUL     = 5;
   localparam int unsigned OP_CLEAR   = 6;
   localparam int unsigned OP_DISPLAY = 7;

   // Operation codes understood by the external ALU
   localparam int unsigned ALU_ADD  = 0;
   localparam int unsigned ALU_SUB  = 1;
   localparam int unsigned ALU_MUL  = 2;
   localparam int unsigned ALU_PASS = 3;

   localparam logic [3:0] S_OFF       = 4'd0;
   localparam logic [3:0] S_INIT_CLR  = 4'd1;
   localparam logic [3:0] S_IDLE      = 4'd2;
   localparam logic [3:0] S_DECODE    = 4'd3;
   localparam logic [3:0] S_READ      = 4'd4;
   localparam logic [3:0] S_EXEC      = 4'd5;
   localparam logic [3:0] S_WRITE     = 4'd6;
   localparam logic [3:0] S_DONE      = 4'd7;
   localparam logic [3:0] S_CLR_SWEEP = 4'd8;

endpackage

// File: rtl/mini_cpu_sweep.sv
// Register-file clear sweep: walks every address once while active and flags the last one.
module mini_cpu_sweep #(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              active,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   // Counter restarts at zero whenever the sweep is not running
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         addr <= '0;
      else if (active)
         addr <= addr + 1'b1;
      else
         addr <= '0;
   end

   assign last = active && (addr == '1);

endmodule

// File: rtl/mini_cpu_core.sv
// Mini-CPU control block: decodes switch instructions on a button edge and sequences
// the dual-read register RAM and the external ALU, publishing results to the LCD.
module mini_cpu_core
   import mini_cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int OP_W     = 3,
   parameter int ALU_OP_W = 4,
   parameter int IMM_W    = 7,
   parameter int INSTR_W  = OP_W + 2*ADDR_W + IMM_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                power_on,
   input  logic                btn_enviar,
   input  logic [INSTR_W-1:0]  instrucao,
   output logic [ADDR_W-1:0]   mem_addr_write,
   output logic [ADDR_W-1:0]   mem_addr_read1,
   output logic [ADDR_W-1:0]   mem_addr_read2,
   output logic [DATA_W-1:0]   mem_data_in,
   input  logic [DATA_W-1:0]   mem_data_out1,
   input  logic [DATA_W-1:0]   mem_data_out2,
   output logic                mem_we,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic [DATA_W-1:0]   alu_in1,
   output logic [DATA_W-1:0]   alu_in2,
   input  logic [DATA_W-1:0]   alu_result,
   output logic [DATA_W-1:0]   reg_result,
   output logic [ADDR_W-1:0]   reg_dest_addr,
   output logic [OP_W-1:0]     reg_opcode,
   output logic                busy,
   output logic                done
);

   logic [3:0]          state, state_n;
   logic                btn_q;
   logic                btn_edge;
   logic [INSTR_W-1:0]  instr_q;
   logic [DATA_W-1:0]   result_q;
   logic [OP_W-1:0]     op;
   logic [ADDR_W-1:0]   dst, src1, src2;
   logic [IMM_W-1:0]    imm;
   logic [DATA_W-1:0]   imm_ext;
   logic                is_load, is_clear, is_display, uses_imm;
   logic [ALU_OP_W-1:0] alu_code;
   logic                sweeping, sweep_last;
   logic [ADDR_W-1:0]   sweep_addr;

   // src2 shares the upper bits of the immediate field
   assign op      = instr_q[INSTR_W-1 -: OP_W];
   assign dst     = instr_q[IMM_W+2*ADDR_W-1 -: ADDR_W];
   assign src1    = instr_q[IMM_W+ADDR_W-1 -: ADDR_W];
   assign src2    = instr_q[IMM_W-1 -: ADDR_W];
   assign imm     = instr_q[IMM_W-1:0];
   assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

   assign is_load    = (op == OP_W'(OP_LOAD));
   assign is_clear   = (op == OP_W'(OP_CLEAR));
   assign is_display = (op == OP_W'(OP_DISPLAY));
   assign uses_imm   = is_load || (op == OP_W'(OP_ADDI)) || (op == OP_W'(OP_SUBI));
   assign btn_edge   = btn_enviar && !btn_q;
   assign sweeping   = (state == S_INIT_CLR) || (state == S_CLR_SWEEP);

   always_comb begin
      alu_code = ALU_OP_W'(ALU_PASS);
      if (op == OP_W'(OP_ADD) || op == OP_W'(OP_ADDI))
         alu_code = ALU_OP_W'(ALU_ADD);
      else if (op == OP_W'(OP_SUB) || op == OP_W'(OP_SUBI))
         alu_code = ALU_OP_W'(ALU_SUB);
      else if (op == OP_W'(OP_MUL))
         alu_code = ALU_OP_W'(ALU_MUL);
   end

   mini_cpu_sweep #(.ADDR_W(ADDR_W)) u_sweep (
      .clk     (clk),
      .reset_n (reset_n),
      .active  (sweeping),
      .addr    (sweep_addr),
      .last    (sweep_last)
   );

   // Dropping power overrides every state so an in-flight instruction never writes back
   always_comb begin
      state_n = state;
      if (!power_on)
         state_n = S_OFF;
      else begin
         case (state)
            S_OFF:       state_n = S_INIT_CLR;
            S_INIT_CLR:  if (sweep_last) state_n = S_IDLE;
            S_IDLE:      if (btn_edge) state_n = S_DECODE;
            S_DECODE:    state_n = is_load ? S_EXEC : (is_clear ? S_CLR_SWEEP : S_READ);
            S_READ:      state_n = S_EXEC;
            S_EXEC:      state_n = S_WRITE;
            S_WRITE:     state_n = S_DONE;
            S_DONE:      state_n = S_IDLE;
            S_CLR_SWEEP: if (sweep_last) state_n = S_DONE;
            default:     state_n = S_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_OFF;
         btn_q <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         btn_q <= btn_enviar;
         done  <= power_on && (state == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instr_q       <= '0;
         result_q      <= '0;
         alu_op        <= '0;
         alu_in1       <= '0;
         alu_in2       <= '0;
         reg_result    <= '0;
         reg_dest_addr <= '0;
         reg_opcode    <= '0;
      end else if (!power_on) begin
         instr_q       <= '0;
         result_q      <= '0;
         alu_op        <= '0;
         alu_in1       <= '0;
         alu_in2       <= '0;
         reg_result    <= '0;
         reg_dest_addr <= '0;
         reg_opcode    <= '0;
      end else begin
         if (state == S_IDLE && btn_edge)
            instr_q <= instrucao;
         // ALU operands are registered on entry to EXEC and then held until the next instruction
         if ((state == S_DECODE && is_load) || state == S_READ) begin
            alu_op  <= alu_code;
            alu_in1 <= is_load ? imm_ext : mem_data_out1;
            alu_in2 <= uses_imm ? imm_ext : mem_data_out2;
         end
         if (state == S_EXEC)
            result_q <= alu_result;
         if (state == S_CLR_SWEEP)
            result_q <= '0;
         if (state == S_DONE) begin
            reg_result    <= result_q;
            reg_dest_addr <= is_display ? src1 : dst;
            reg_opcode    <= op;
         end
      end
   end

   assign mem_we         = sweeping || (state == S_WRITE && !is_display);
   assign mem_addr_write = sweeping ? sweep_addr : dst;
   assign mem_data_in    = sweeping ? '0 : result_q;
   assign mem_addr_read1 = src1;
   assign mem_addr_read2 = src2;
   assign busy           = (state != S_IDLE) && (state != S_OFF);

endmodule

// File: tb/tb_mini_cpu_core.sv
// Directed bench for mini_cpu_core with a 16x16 synchronous-read RAM model and an ALU model.
module tb_mini_cpu_core;

   logic        clk = 1'b0;
   logic        reset_n, power_on, btn_enviar;
   logic [17:0] instrucao;
   logic [3:0]  mem_addr_write, mem_addr_read1, mem_addr_read2;
   logic [15:0] mem_data_in, mem_data_out1, mem_data_out2;
   logic        mem_we;
   logic [3:0]  alu_op;
   logic [15:0] alu_in1, alu_in2, alu_result;
   logic [15:0] reg_result;
   logic [3:0]  reg_dest_addr;
   logic [2:0]  reg_opcode;
   logic        busy, done;

   int n_compared   = 0;
   int n_mismatched = 0;
   int we_count     = 0;
   int done_count   = 0;
   logic [15:0] ram [16];

   mini_cpu_core dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .power_on       (power_on),
      .btn_enviar     (btn_enviar),
      .instrucao      (instrucao),
      .mem_addr_write (mem_addr_write),
      .mem_addr_read1 (mem_addr_read1),
      .mem_addr_read2 (mem_addr_read2),
      .mem_data_in    (mem_data_in),
      .mem_data_out1  (mem_data_out1),
      .mem_data_out2  (mem_data_out2),
      .mem_we         (mem_we),
      .alu_op         (alu_op),
      .alu_in1        (alu_in1),
      .alu_in2        (alu_in2),
      .alu_result     (alu_result),
      .reg_result     (reg_result),
      .reg_dest_addr  (reg_dest_addr),
      .reg_opcode     (reg_opcode),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   // Register RAM: one write port, two synchronous read ports
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr_write] <= mem_data_in;
         we_count <= we_count + 1;
      end
      mem_data_out1 <= ram[mem_addr_read1];
      mem_data_out2 <= ram[mem_addr_read2];
   end

   // External ALU: add, sub, mul (truncated to 16 bits), pass operand A
   always_comb begin
      case (alu_op)
         4'd0:    alu_result = alu_in1 + alu_in2;
         4'd1:    alu_result = alu_in1 - alu_in2;
         4'd2:    alu_result = alu_in1 * alu_in2;
         4'd3:    alu_result = alu_in1;
         default: alu_result = 16'h0000;
      endcase
   end

   always @(negedge clk) if (done === 1'b1) done_count <= done_count + 1;

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [17:0] enc(input logic [2:0] op, input logic [3:0] dst,
                                       input logic [3:0] s1, input logic [6:0] last);
      return {op, dst, s1, last};
   endfunction

   function automatic logic [6:0] rs2(input logic [3:0] s2);
      return {s2, 3'b000};
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_compared++;
      assert (obs === exp) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Counts clock edges (after the edge-capturing one) until done is seen high; -1 on timeout
   task automatic wait_done(input int start, output int lat);
      bit seen;
      seen = 1'b0;
      lat  = start;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         lat++;
         #1;
         if (done === 1'b1) seen = 1'b1;
      end
      if (!seen) lat = -1;
   endtask

   task automatic apply_stimulus(input logic [17:0] ins, output int lat);
      @(negedge clk);
      instrucao  = ins;
      btn_enviar = 1'b1;
      @(posedge clk);
      wait_done(0, lat);
      @(negedge clk);
      btn_enviar = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_not_busy();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy === 1'b0) break;
      end
   endtask

   initial begin
      int lat, w0, d0, zeros;

      reset_n    = 1'b0;
      power_on   = 1'b0;
      btn_enviar = 1'b0;
      instrucao  = '0;
      repeat (3) @(negedge clk);
      check_output("reset_busy", busy, 0);
      check_output("reset_done", done, 0);
      check_output("reset_we", mem_we, 0);
      check_output("reset_result", reg_result, 0);
      check_output("reset_dest", reg_dest_addr, 0);
      check_output("reset_opcode", reg_opcode, 0);
      check_output("reset_alu_in1", alu_in1, 0);
      reset_n = 1'b1;
      @(negedge clk);
      check_output("off_busy", busy, 0);

      $display("[TB] power-on clear sweep");
      w0 = we_count;
      power_on = 1'b1;
      @(posedge clk);
      #1;
      check_output("init_busy", busy, 1);
      wait_not_busy();
      check_output("init_idle", busy, 0);
      check_output("init_writes", we_count - w0, 16);
      zeros = 0;
      for (int i = 0; i < 16; i++) if (ram[4'(i)] === 16'h0000) zeros++;
      check_output("init_zero", zeros, 16);

      $display("[TB] LOAD r3,#-5");
      apply_stimulus(enc(3'd0, 4'd3, 4'd0, 7'h7B), lat);
      check_output("load_lat", lat, 4);
      check_output("load_ram", ram[3], 16'hFFFB);
      check_output("load_result", reg_result, 16'hFFFB);
      check_output("load_dest", reg_dest_addr, 3);
      check_output("load_opcode", reg_opcode, 0);

      apply_stimulus(enc(3'd0, 4'd1, 4'd0, 7'd50), lat);
      apply_stimulus(enc(3'd1, 4'd1, 4'd1, rs2(4'd1)), lat);
      check_output("add_lat", lat, 5);
      check_output("add_r1", ram[1], 16'd100);
      apply_stimulus(enc(3'd0, 4'd2, 4'd0, 7'd30), lat);
      check_output("load_r2", ram[2], 16'd30);

      $display("[TB] SUB r4,r1,r2");
      apply_stimulus(enc(3'd3, 4'd4, 4'd1, rs2(4'd2)), lat);
      check_output("sub_lat", lat, 5);
      check_output("sub_r4", ram[4], 16'd70);
      check_output("sub_opcode", reg_opcode, 3);

      $display("[TB] MUL r5,r4,r4 with a second press while busy");
      d0 = done_count;
      @(negedge clk);
      instrucao  = enc(3'd5, 4'd5, 4'd4, rs2(4'd4));
      btn_enviar = 1'b1;
      @(posedge clk);
      @(negedge clk);
      btn_enviar = 1'b0;
      @(negedge clk);
      btn_enviar = 1'b1;
      instrucao  = enc(3'd0, 4'd7, 4'd0, 7'd5);
      wait_done(1, lat);
      check_output("mul_lat", lat, 5);
      @(negedge clk);
      btn_enviar = 1'b0;
      repeat (4) @(negedge clk);
      check_output("mul_r5", ram[5], 16'd4900);
      check_output("mul_single_done", done_count - d0, 1);
      check_output("mul_no_queue", ram[7], 16'h0000);
      check_output("mul_idle", busy, 0);

      apply_stimulus(enc(3'd2, 4'd6, 4'd2, 7'h46), lat);
      check_output("addi_wrap", ram[6], 16'hFFE4);
      apply_stimulus(enc(3'd4, 4'd9, 4'd1, 7'd63), lat);
      check_output("subi_r9", ram[9], 16'd37);

      $display("[TB] DISPLAY r4");
      w0 = we_count;
      apply_stimulus(enc(3'd7, 4'd0, 4'd4, 7'd0), lat);
      check_output("disp_lat", lat, 5);
      check_output("disp_no_write", we_count - w0, 0);
      check_output("disp_result", reg_result, 16'd70);
      check_output("disp_dest", reg_dest_addr, 4);
      check_output("disp_opcode", reg_opcode, 7);

      $display("[TB] CLEAR");
      w0 = we_count;
      apply_stimulus(enc(3'd6, 4'd0, 4'd0, 7'd0), lat);
      check_output("clear_lat", lat, 18);
      check_output("clear_writes", we_count - w0, 16);
      check_output("clear_result", reg_result, 0);
      check_output("clear_opcode", reg_opcode, 6);
      check_output("clear_r5", ram[5], 16'h0000);

      $display("[TB] power off during EXEC");
      apply_stimulus(enc(3'd0, 4'd1, 4'd0, 7'd9), lat);
      w0 = we_count;
      d0 = done_count;
      @(negedge clk);
      instrucao  = enc(3'd1, 4'd8, 4'd1, rs2(4'd1));
      btn_enviar = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_output("exec_alu_in1", alu_in1, 16'd9);
      power_on = 1'b0;
      @(posedge clk);
      #1;
      check_output("pwroff_busy", busy, 0);
      check_output("pwroff_we", mem_we, 0);
      check_output("pwroff_result", reg_result, 0);
      check_output("pwroff_alu_in1", alu_in1, 0);
      repeat (3) @(negedge clk);
      check_output("pwroff_no_write", we_count - w0, 0);
      check_output("pwroff_no_done", done_count - d0, 0);
      check_output("pwroff_r8", ram[8], 16'h0000);

      $display("[TB] button held across power-on");
      instrucao = enc(3'd0, 4'd9, 4'd0, 7'd7);
      repeat (2) @(negedge clk);
      d0 = done_count;
      power_on = 1'b1;
      @(negedge clk);
      wait_not_busy();
      repeat (8) @(negedge clk);
      check_output("held_no_done", done_count - d0, 0);
      check_output("held_r9", ram[9], 16'h0000);
      btn_enviar = 1'b0;
      apply_stimulus(enc(3'd0, 4'd9, 4'd0, 7'd7), lat);
      check_output("repress_lat", lat, 4);
      check_output("repress_r9", ram[9], 16'd7);
      check_output("repress_dest", reg_dest_addr, 9);

      $display("[TB] async reset during CLEAR");
      @(negedge clk);
      instrucao  = enc(3'd6, 4'd0, 4'd0, 7'd0);
      btn_enviar = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check_output("clr_mid_we", mem_we, 1);
      reset_n = 1'b0;
      #1;
      check_output("rst_busy", busy, 0);
      check_output("rst_we", mem_we, 0);
      check_output("rst_dest", reg_dest_addr, 0);
      check_output("rst_result", reg_result, 0);
      check_output("rst_done", done, 0);
      @(negedge clk);
      btn_enviar = 1'b0;
      reset_n    = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
